instr_mem_banked: RTL and testbench

Parametrised, byte-addressed, big-endian instruction memory for the ARM pipeline's fetch stage. It adds a self-clearing init sequence, a registered fetch port with stall/valid handshake and misalignment flagging, and a byte-enabled write port used by the boot loader and test benches to program the array. Reads are synchronous: one clock from accepted request to data.

---
 rtl/instr_mem_banked_pkg.sv | 5 +
 rtl/instr_mem_array.sv | 25 ++
 rtl/instr_mem_banked.sv | 81 ++++++++
 tb/tb_instr_mem_banked.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/instr_mem_banked_pkg.sv
// instr_mem_banked_pkg: shared state type and fill encoding for the banked instruction memory
package instr_mem_banked_pkg;
    typedef enum logic {INIT, RUN} state_t;
    localparam logic [31:0] NOP_AL = 32'hE000_0000;
endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array: byte-lane banked storage, synchronous read, byte-enabled write
module instr_mem_array #(
    parameter int BYTE_W      = 8,
    parameter int WORD_BYTES  = 4,
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                         clk,
    input  logic [WORD_BYTES-1:0]        we,
    input  logic [IDX_W-1:0]             waddr,
    input  logic [WORD_BYTES*BYTE_W-1:0] wdata,
    input  logic                         re,
    input  logic [IDX_W-1:0]             raddr,
    output logic [WORD_BYTES*BYTE_W-1:0] rdata
);
    for (genvar b = 0; b < WORD_BYTES; b++) begin : g_bank
        logic [BYTE_W-1:0] mem [DEPTH_WORDS];
        logic [BYTE_W-1:0] q;
        always_ff @(posedge clk) begin
            if (we[b]) mem[waddr] <= wdata[b*BYTE_W +: BYTE_W];
            if (re) q <= mem[raddr];
        end
        assign rdata[b*BYTE_W +: BYTE_W] = q;
    end
endmodule

// File: rtl/instr_mem_banked.sv
// instr_mem_banked: self-initialising instruction memory with registered fetch port and byte-enabled write port
module instr_mem_banked
    import instr_mem_banked_pkg::*;
#(
    parameter int                              BYTE_W      = 8,
    parameter int                              WORD_BYTES  = 4,
    parameter int                              DEPTH_WORDS = 256,
    parameter int                              ADDR_W      = 32,
    parameter logic [WORD_BYTES*BYTE_W-1:0]    FILL_WORD   = NOP_AL
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         ready,
    input  logic                         fetch_req,
    input  logic [ADDR_W-1:0]            fetch_addr,
    input  logic                         fetch_stall,
    output logic                         fetch_valid,
    output logic [WORD_BYTES*BYTE_W-1:0] fetch_data,
    output logic                         fetch_misalign,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [WORD_BYTES*BYTE_W-1:0] wr_data,
    input  logic [WORD_BYTES-1:0]        wr_byte_en
);
    localparam int OFF_W  = $clog2(WORD_BYTES);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int DATA_W = WORD_BYTES * BYTE_W;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    cnt;
    logic                sel_fill, accept, aligned, unused_addr;
    logic [WORD_BYTES-1:0] arr_we;
    logic [IDX_W-1:0]    arr_waddr;
    logic [DATA_W-1:0]   arr_wdata, rdata;

    assign aligned     = (fetch_addr & ADDR_W'(WORD_BYTES - 1)) == '0;
    assign accept      = ready & fetch_req & ~(fetch_valid & fetch_stall);
    assign unused_addr = ^{fetch_addr, wr_addr};

    always_comb begin
        state_nxt = (state == INIT && cnt == IDX_W'(DEPTH_WORDS - 1)) ? RUN : state;
        arr_we    = (state == INIT) ? '1 : (wr_en ? wr_byte_en : '0);
        arr_waddr = (state == INIT) ? cnt : wr_addr[OFF_W +: IDX_W];
        arr_wdata = (state == INIT) ? FILL_WORD : wr_data;
    end

    // misaligned fetches and the post-reset value both select FILL_WORD rather than the array output
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= INIT;
            cnt            <= '0;
            ready          <= 1'b0;
            fetch_valid    <= 1'b0;
            fetch_misalign <= 1'b0;
            sel_fill       <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= (state == INIT) ? cnt + 1'b1 : cnt;
            ready       <= state_nxt == RUN;
            fetch_valid <= accept | (fetch_valid & fetch_stall);
            if (accept) begin
                fetch_misalign <= ~aligned;
                sel_fill       <= ~aligned;
            end
        end
    end

    assign fetch_data = sel_fill ? FILL_WORD : rdata;

    instr_mem_array #(
        .BYTE_W(BYTE_W), .WORD_BYTES(WORD_BYTES), .DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)
    ) u_array (
        .clk(clk),
        .we(arr_we),
        .waddr(arr_waddr),
        .wdata(arr_wdata),
        .re(accept & aligned),
        .raddr(fetch_addr[OFF_W +: IDX_W]),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_instr_mem_banked.sv
// tb_instr_mem_banked: randomized and directed checks against a byte-array reference model
module tb_instr_mem_banked;
    localparam logic [31:0] FILL = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        rst, ready, fetch_req, fetch_stall, fetch_valid, fetch_misalign, wr_en;
    logic [31:0] fetch_addr, fetch_data, wr_addr, wr_data;
    logic [3:0]  wr_byte_en;

    always #5 clk = ~clk;

    instr_mem_banked dut (
        .clk(clk), .rst(rst), .ready(ready),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_misalign(fetch_misalign),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en)
    );

    logic [7:0]  mem_m [1024];
    logic        m_ready, m_valid, m_mis, m_init;
    logic [31:0] m_data;
    int          m_cnt;
    int          vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_m(input logic [31:0] a);
        int b = int'(a & 32'h3FC);
        return {mem_m[b], mem_m[b+1], mem_m[b+2], mem_m[b+3]};
    endfunction

    task automatic cyc(input logic r, input logic req, input logic [31:0] fa, input logic st,
                       input logic we, input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be);
        logic        acc;
        logic [31:0] f = FILL;
        int          base;
        rst = r; fetch_req = req; fetch_addr = fa; fetch_stall = st;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_byte_en = be;
        if (r) begin
            m_ready = 0; m_valid = 0; m_mis = 0; m_data = FILL; m_cnt = 0; m_init = 1;
        end else if (m_init) begin
            m_cnt++;
            if (m_cnt == 256) begin
                m_init = 0; m_ready = 1;
                for (int i = 0; i < 1024; i++) mem_m[i] = f[31 - 8*(i % 4) -: 8];
            end
        end else begin
            acc = m_ready && req && !(m_valid && st);
            m_valid = acc || (m_valid && st);
            if (acc) begin
                m_mis  = fa[1:0] != 2'b00;
                m_data = m_mis ? FILL : rd_m(fa);
            end
            base = int'(wa & 32'h3FC);
            if (we) for (int k = 0; k < 4; k++) if (be[k]) mem_m[base + 3 - k] = wd[k*8 +: 8];
        end
        @(posedge clk);
        #1;
        chk("ready", {31'b0, ready}, {31'b0, m_ready});
        chk("valid", {31'b0, fetch_valid}, {31'b0, m_valid});
        chk("data", fetch_data, m_data);
        chk("misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fetch(input logic [31:0] a);
        cyc(0, 1, a, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] fa, wa;
        rst = 1; fetch_req = 0; fetch_addr = 0; fetch_stall = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0; wr_byte_en = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (255) idle();
        chk("init_not_ready", {31'b0, ready}, 32'd0);
        idle();
        chk("init_ready", {31'b0, ready}, 32'd1);

        fetch(32'h000);
        chk("fill_000", fetch_data, 32'hE000_0000);
        fetch(32'h3FC);
        chk("fill_3fc", fetch_data, 32'hE000_0000);

        cyc(0, 0, 0, 0, 1, 32'h004, 32'hE3A0_0014, 4'b1111);
        fetch(32'h004);
        chk("wr_full", fetch_data, 32'hE3A0_0014);
        cyc(0, 0, 0, 0, 1, 32'h004, 32'h0000_00FF, 4'b0001);
        fetch(32'h004);
        chk("wr_byte", fetch_data, 32'hE3A0_00FF);

        cyc(0, 1, 32'h008, 0, 1, 32'h008, 32'h1234_5678, 4'b1111);
        chk("rbw_old", fetch_data, 32'hE000_0000);
        fetch(32'h008);
        chk("rbw_new", fetch_data, 32'h1234_5678);

        fetch(32'h00A);
        chk("mis_flag", {31'b0, fetch_misalign}, 32'd1);
        chk("mis_data", fetch_data, 32'hE000_0000);
        fetch(32'h408);
        chk("wrap", fetch_data, 32'h1234_5678);

        fetch(32'h000);
        repeat (3) begin
            cyc(0, 1, 32'h004, 1, 0, 0, 0, 0);
            chk("stall_hold", fetch_data, 32'hE000_0000);
            chk("stall_valid", {31'b0, fetch_valid}, 32'd1);
        end
        fetch(32'h004);
        chk("stall_release", fetch_data, 32'hE3A0_00FF);

        for (int i = 0; i < 2000; i++) begin
            fa = ($urandom & 32'hFFFF_FC3C) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            wa = $urandom & 32'hFFFF_FC3F;
            cyc(i == 1000, $urandom_range(0, 3) != 0, fa, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, wa, $urandom, 4'($urandom));
        end

        cyc(0, 0, 0, 0, 1, 32'h010, 32'hDEAD_BEEF, 4'b1111);
        cyc(0, 1, 32'h010, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'h010, 0, 0, 0, 0, 0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
        repeat (256) idle();
        for (int w = 0; w < 256; w++) begin
            fetch(32'(w * 4));
            chk("post_rst_clear", fetch_data, 32'hE000_0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
